// File: rtl/matrix_mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared types and helpers for the sequential N x N matrix multiplier.
//   state_e        : job FSM states (IDLE -> LOAD -> RUN -> DONE -> IDLE)
//   acc_w_default  : accumulator width that cannot overflow for an N-term
//                    sum of DATA_W x DATA_W unsigned products
//   run_steps      : number of RUN edges for a given N (3N-2)
//   RUN_STEPS_DEF  : RUN edge count for the default 3x3 build
// -----------------------------------------------------------------------------
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_N     = 3;
  localparam int RUN_STEPS_DEF = 3 * DEFAULT_N - 2;

  function automatic int acc_w_default(input int n, input int data_w);
    return 2 * data_w + $clog2(n);
  endfunction

  // The last PE (N-1,N-1) sees its final term at k = (N-1)+(N-1)+(N-1),
  // so k must walk 0..3N-3.
  function automatic int run_steps(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/matrix_mult_seq_mac_pe.sv
// -----------------------------------------------------------------------------
// mac_pe
// Registered unsigned multiply-accumulate cell.
//   clk    : rising-edge clock
//   Reset  : asynchronous, active-low; clears Acc
//   Clear  : synchronous clear of Acc (wins over En)
//   En     : add Ain*Bin into Acc on this edge
//   Ain    : DATA_W-bit operand
//   Bin    : DATA_W-bit operand
//   Acc    : ACC_W-bit running sum
// -----------------------------------------------------------------------------
module mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              En,
  input  logic [DATA_W-1:0] Ain,
  input  logic [DATA_W-1:0] Bin,
  output logic [ACC_W-1:0]  Acc
);

  // Operands widened first so the product keeps all 2*DATA_W bits.
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, Ain} * {{DATA_W{1'b0}}, Bin};

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      Acc <= '0;
    end else if (Clear) begin
      Acc <= '0;
    end else if (En) begin
      Acc <= Acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/matrix_mult_seq.sv
// -----------------------------------------------------------------------------
// matrix_mult_seq
// N x N unsigned matrix multiplier, C = A * B, using an N x N grid of mac_pe
// cells fed on a skewed schedule: on RUN step k, PE(i,j) adds term t=k-i-j
// when 0 <= t < N.
//
// Ports
//   clk       : rising-edge clock
//   Reset     : asynchronous, active-low reset
//   Start     : job request, sampled only in IDLE
//   A, B      : operands, element (i,j) at [(i*N+j)*DATA_W +: DATA_W]
//   C         : registered result, element (i,j) at [(i*N+j)*OUT_W +: OUT_W]
//   Busy      : high in LOAD and RUN
//   Done      : one-cycle pulse in DONE; C already holds the new result
//   state_dbg : current FSM state
//
// Handshake: Start is a request level sampled at an edge only while idle; once
// taken, A and B are captured in LOAD and may change freely afterwards. Busy
// covers the whole job, Done marks result-valid for one cycle, and Start seen
// outside IDLE is dropped (no queuing). C holds until the next job completes.
//
// Build option: define MATRIX_SAT_EN to saturate C elements at 2^OUT_W-1
// instead of keeping the low OUT_W bits. Assumes OUT_W <= ACC_W.
// -----------------------------------------------------------------------------
module matrix_mult_seq
  import matrix_pkg::*;
#(
  parameter int N      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = acc_w_default(N, DATA_W),
  parameter int OUT_W  = 8
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [N*N*DATA_W-1:0]   A,
  input  logic [N*N*DATA_W-1:0]   B,
  output logic [N*N*OUT_W-1:0]    C,
  output logic                    Busy,
  output logic                    Done,
  output state_e                  state_dbg
);

  localparam int             STEPS  = run_steps(N);
  localparam int             K_W    = $clog2(STEPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(STEPS - 1);

  state_e            state;
  logic [K_W-1:0]    k;
  logic              load;
  logic              run;
  logic              last;
  logic [DATA_W-1:0] a_reg [N][N];
  logic [DATA_W-1:0] b_reg [N][N];
  logic [N*N*OUT_W-1:0] c_nxt;

  assign load = (state == LOAD);
  assign run  = (state == RUN);
  assign last = run && (k == K_LAST);

  function automatic logic [OUT_W-1:0] out_rule(input logic [ACC_W-1:0] v);
`ifdef MATRIX_SAT_EN
    if ((v >> OUT_W) != '0) return '1;
    return v[OUT_W-1:0];
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Job FSM and step counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      case (state)
        IDLE: if (Start) state <= LOAD;
        LOAD: begin
          k     <= '0;
          state <= RUN;
        end
        RUN: begin
          if (k == K_LAST) state <= DONE;
          else             k     <= k + K_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture: the job runs on these copies, not on the live A/B.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
      end
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_reg[i][j] <= A[(i*N+j)*DATA_W +: DATA_W];
          b_reg[i][j] <= B[(i*N+j)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PE grid with term-select muxes
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic              en;
      logic [DATA_W-1:0] a_sel;
      logic [DATA_W-1:0] b_sel;
      logic [ACC_W-1:0]  acc;
      logic [ACC_W-1:0]  acc_fin;

      // At most one t matches k, so this is a plain N-way select.
      always_comb begin
        en    = 1'b0;
        a_sel = '0;
        b_sel = '0;
        for (int t = 0; t < N; t++) begin
          if (k == K_W'(t + i + j)) begin
            en    = run;
            a_sel = a_reg[i][t];
            b_sel = b_reg[t][j];
          end
        end
      end

      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .Reset (Reset),
        .Clear (load),
        .En    (en),
        .Ain   (a_sel),
        .Bin   (b_sel),
        .Acc   (acc)
      );

      // C is written on the last RUN edge, which is also the edge where the
      // corner PE adds its final term; only that PE needs the sum bypassed.
      if (i == N - 1 && j == N - 1) begin : g_corner
        assign acc_fin = acc + ACC_W'({{DATA_W{1'b0}}, a_sel} * {{DATA_W{1'b0}}, b_sel});
      end else begin : g_plain
        assign acc_fin = acc;
      end

      assign c_nxt[(i*N+j)*OUT_W +: OUT_W] = out_rule(acc_fin);
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset)    C <= '0;
    else if (last) C <= c_nxt;
  end

  assign Busy      = load | run;
  assign Done      = (state == DONE);
  assign state_dbg = state;

endmodule
